code_hold_ctrl: RTL and testbench

- Parametrised tick-triggered data hold stage.
- When `tick` fires, it captures `data_in` and drives it on `data_out` for a programmable number of clock cycles. On expiry it returns `data_out` to a fixed idle value.
- Adds retrigger, track/latch and abort behaviour, plus `active`/`done` status, so keypad/UART-style code paths can share one block.
- Sits between a code source (decoder, receiver) and a display or consumer that needs a stretched code.

---
 rtl/code_hold_ctrl.sv | 97 +++++++++
 tb/tb_code_hold_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_hold_ctrl.sv
// Tick-triggered code hold stage: captures data_in on tick and presents it on
// data_out for HOLD_CYCLES+1 cycles, with retrigger, track and abort options.
module code_hold_ctrl #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      HOLD_CYCLES = 5000000,
    parameter int unsigned      CNT_W       = 23,
    parameter int unsigned      RETRIGGER   = 1,
    parameter int unsigned      TRACK       = 1,
    parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             active,
    output logic             done
);

    if (HOLD_CYCLES == 0 ||
        longint'(HOLD_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_hold
        $error("code_hold_ctrl: HOLD_CYCLES must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] data_n;
    logic             done_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= IDLE_VALUE;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            data_out <= data_n;
            done     <= done_n;
        end
    end

    // Priority is abort > tick > counting; a retrigger on the cnt==0 cycle
    // pre-empts expiry, so no done pulse is produced for that hold.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        data_n  = data_out;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!abort && tick) begin
                    state_n = HOLD;
                    cnt_n   = HOLD_LOAD;
                    data_n  = data_in;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    data_n  = IDLE_VALUE;
                end else if (tick && (RETRIGGER != 0)) begin
                    cnt_n  = HOLD_LOAD;
                    data_n = data_in;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_ONE;
                    if (TRACK != 0) begin
                        data_n = data_in;
                    end
                end else begin
                    state_n = IDLE;
                    data_n  = IDLE_VALUE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                data_n  = IDLE_VALUE;
            end
        endcase
    end

    assign active = (state == HOLD);

endmodule

// File: tb/tb_code_hold_ctrl.sv
// Directed bench for code_hold_ctrl: three parameter variants driven in common,
// a vector table per scenario plus hand-written reset/duration sequences.
module tb_code_hold_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] d0, d1, d2;
    logic       a0, a1, a2;
    logic       dn0, dn1, dn2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // dut0: TRACK=0 RETRIGGER=1, dut1: TRACK=1 RETRIGGER=1, dut2: TRACK=0 RETRIGGER=0
    code_hold_ctrl #(.WIDTH(8), .HOLD_CYCLES(4), .CNT_W(23), .RETRIGGER(1), .TRACK(0),
                     .IDLE_VALUE(8'h00)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .abort(abort),
        .data_in(data_in), .data_out(d0), .active(a0), .done(dn0));

    code_hold_ctrl #(.WIDTH(8), .HOLD_CYCLES(4), .CNT_W(23), .RETRIGGER(1), .TRACK(1),
                     .IDLE_VALUE(8'h00)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .abort(abort),
        .data_in(data_in), .data_out(d1), .active(a1), .done(dn1));

    code_hold_ctrl #(.WIDTH(8), .HOLD_CYCLES(4), .CNT_W(3), .RETRIGGER(0), .TRACK(0),
                     .IDLE_VALUE(8'h00)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .abort(abort),
        .data_in(data_in), .data_out(d2), .active(a2), .done(dn2));

    typedef struct {
        bit         seg;
        int         sel;
        bit         tk;
        bit         ab;
        logic [7:0] din;
        logic [7:0] ed;
        bit         ea;
        bit         edn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit seg, input int sel, input bit tk, input bit ab,
                       input logic [7:0] din, input logic [7:0] ed,
                       input bit ea, input bit edn);
        vec_t v;
        v.seg = seg; v.sel = sel; v.tk = tk; v.ab = ab;
        v.din = din; v.ed = ed; v.ea = ea; v.edn = edn;
        vecs.push_back(v);
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick = 1'b0; abort = 1'b0; data_in = 8'h00;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] gd;
        logic       ga, gdn;
        int         n_act;
        bit         fell;

        // Scenario 1: single trigger, TRACK=0
        add(1, 0, 1, 0, 8'h5A, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h33, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h33, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h33, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h33, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h33, 8'h00, 0, 1);
        add(0, 0, 0, 0, 8'h33, 8'h00, 0, 0);
        // Scenario 2: TRACK=1
        add(1, 1, 1, 0, 8'h10, 8'h10, 1, 0);
        add(0, 1, 0, 0, 8'h11, 8'h11, 1, 0);
        add(0, 1, 0, 0, 8'h12, 8'h12, 1, 0);
        add(0, 1, 0, 0, 8'h13, 8'h13, 1, 0);
        add(0, 1, 0, 0, 8'h14, 8'h14, 1, 0);
        add(0, 1, 0, 0, 8'h15, 8'h00, 0, 1);
        add(0, 1, 0, 0, 8'h16, 8'h00, 0, 0);
        // Scenario 3a: retrigger two cycles after first tick, 7 active cycles
        add(1, 0, 1, 0, 8'hA1, 8'hA1, 1, 0);
        add(0, 0, 0, 0, 8'h77, 8'hA1, 1, 0);
        add(0, 0, 1, 0, 8'hB2, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h77, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h77, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h77, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h77, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h77, 8'h00, 0, 1);
        add(0, 0, 0, 0, 8'h77, 8'h00, 0, 0);
        // Scenario 3b: retrigger on the cnt==0 cycle, no done at that edge
        add(1, 0, 1, 0, 8'hA1, 8'hA1, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 0, 1, 0, 8'hB2, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'hB2, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 1);
        // Scenario 4a: RETRIGGER=0, second tick ignored
        add(1, 2, 1, 0, 8'hA1, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h77, 8'hA1, 1, 0);
        add(0, 2, 1, 0, 8'hB2, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h77, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h77, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h77, 8'h00, 0, 1);
        add(0, 2, 0, 0, 8'h77, 8'h00, 0, 0);
        // Scenario 4b: RETRIGGER=0, tick on cnt==0 cycle does not extend
        add(1, 2, 1, 0, 8'hA1, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 2, 0, 0, 8'h00, 8'hA1, 1, 0);
        add(0, 2, 1, 0, 8'hB2, 8'h00, 0, 1);
        add(0, 2, 0, 0, 8'h00, 8'h00, 0, 0);
        // Scenario 5: abort on 3rd hold cycle, then abort+tick in IDLE
        add(1, 0, 1, 0, 8'h5A, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h5A, 1, 0);
        add(0, 0, 0, 0, 8'h00, 8'h5A, 1, 0);
        add(0, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 1, 1, 8'hC7, 8'h00, 0, 0);
        add(0, 0, 0, 0, 8'h00, 8'h00, 0, 0);

        // Reset state, sampled while reset is still asserted
        #12;
        chk8("rst_data0", d0, 8'h00); chk1("rst_act0", a0, 1'b0); chk1("rst_done0", dn0, 1'b0);
        chk8("rst_data1", d1, 8'h00); chk8("rst_data2", d2, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].seg) do_reset();
            @(negedge clk);
            tick = vecs[i].tk; abort = vecs[i].ab; data_in = vecs[i].din;
            @(posedge clk);
            #1;
            case (vecs[i].sel)
                0:       begin gd = d0; ga = a0; gdn = dn0; end
                1:       begin gd = d1; ga = a1; gdn = dn1; end
                default: begin gd = d2; ga = a2; gdn = dn2; end
            endcase
            chk8($sformatf("vec%0d_data", i), gd, vecs[i].ed);
            chk1($sformatf("vec%0d_active", i), ga, vecs[i].ea);
            chk1($sformatf("vec%0d_done", i), gdn, vecs[i].edn);
        end

        // Scenario 6: asynchronous reset between edges during HOLD
        do_reset();
        @(negedge clk);
        tick = 1'b1; data_in = 8'h5A;
        @(negedge clk);
        tick = 1'b0;
        @(posedge clk);
        #2;
        chk1("pre_arst_active", a0, 1'b1);
        reset = 1'b0;
        #1;
        chk8("arst_data0", d0, 8'h00); chk1("arst_act0", a0, 1'b0); chk1("arst_done0", dn0, 1'b0);
        chk8("arst_data1", d1, 8'h00); chk1("arst_act1", a1, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // After release, a fresh trigger gives exactly 5 active cycles then done
        @(negedge clk);
        tick = 1'b1; data_in = 8'hC3;
        @(negedge clk);
        tick = 1'b0; data_in = 8'h00;
        n_act = 0;
        fell = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!a0) begin
                fell = 1'b1;
                chk1("post_arst_done", dn0, 1'b1);
                chk8("post_arst_idle", d0, 8'h00);
                break;
            end
            chk8($sformatf("post_arst_hold%0d", i), d0, 8'hC3);
            n_act++;
            @(negedge clk);
        end
        chk1("post_arst_expired", fell, 1'b1);
        checks++;
        if (n_act != 5) begin
            errors++;
            $display("FAIL post_arst_len: got %0d expected %0d", n_act, 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
